// File: rtl/cover_pkg.sv
// Shared types and helpers for the toggle-coverage collector.
//   cover_idx_t  : 64-bit global cover-point index
//   popcount     : number of set bits in a (zero-extended) 256-bit vector
//   lowest_set   : priority encoder, lowest set bit index plus found flag
package cover_pkg;

  localparam int unsigned COVER_IDX_W = 64;
  localparam int unsigned MAX_WIDTH   = 256;

  typedef logic [COVER_IDX_W-1:0] cover_idx_t;

  typedef struct packed {
    logic       found;
    logic [7:0] index;
  } lowest_t;

  function automatic logic [8:0] popcount(input logic [MAX_WIDTH-1:0] v);
    logic [8:0] cnt;
    cnt = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      cnt = cnt + 9'(v[i]);
    end
    return cnt;
  endfunction

  function automatic lowest_t lowest_set(input logic [MAX_WIDTH-1:0] v);
    lowest_t r;
    r = '0;
    // Scan downwards so the last hit written is the lowest set bit.
    for (int i = MAX_WIDTH - 1; i >= 0; i--) begin
      if (v[i]) begin
        r.found = 1'b1;
        r.index = 8'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/cover_idx_fifo.sv
// Synchronous show-ahead FIFO of cover indices.
//   clock, reset (async active-low), flush (sync, wins over push/pop)
//   push/push_data/full : write side; a push while full is taken only with a pop
//   pop/empty/head      : read side; head is the oldest entry, zero when empty
module cover_idx_fifo
  import cover_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       flush,
  input  logic       push,
  input  cover_idx_t push_data,
  output logic       full,
  input  logic       pop,
  output logic       empty,
  output cover_idx_t head
);

  localparam int unsigned AW = $clog2(DEPTH);

  cover_idx_t    mem [DEPTH];
  logic [AW:0]   wr_q, wr_d;
  logic [AW:0]   rd_q, rd_d;
  logic          do_push, do_pop;

  // Extra pointer bit distinguishes full from empty.
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head  = empty ? '0 : mem[rd_q[AW-1:0]];

  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset: head is masked while empty.
  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/cover_toggle_collector.sv
// Toggle-coverage collector for WIDTH cover points at global indices
// COVER_INDEX .. COVER_INDEX+WIDTH-1.
//   clock, reset (async active-low), clear (sync, highest priority after reset)
//   enable, valid[WIDTH]           : toggle events, ignored while enable is low
//   report_valid/ready/index       : each first hit, once, ascending per batch
//   hit_map, hit_count, all_hit    : sticky coverage state
module cover_toggle_collector
  import cover_pkg::*;
#(
  parameter int unsigned WIDTH       = 40,
  parameter int unsigned COVER_INDEX = 0,
  parameter int unsigned COVER_TOTAL = 8940,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [WIDTH-1:0]           valid,
  input  logic                       clear,
  output logic                       report_valid,
  input  logic                       report_ready,
  output cover_idx_t                 report_index,
  output logic [WIDTH-1:0]           hit_map,
  output logic [$clog2(WIDTH+1)-1:0] hit_count,
  output logic                       all_hit
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("cover_toggle_collector: WIDTH out of range 1..256");
  end
  if (COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_bad_range
    $error("cover_toggle_collector: cover group exceeds COVER_TOTAL");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("cover_toggle_collector: FIFO_DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] hit_map_q, hit_map_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [CntW-1:0]  hit_count_q, hit_count_d;
  logic             all_hit_q, all_hit_d;
  logic [WIDTH-1:0] new_hits;
  lowest_t          sel;
  logic             fifo_push, fifo_full, fifo_empty;
  cover_idx_t       push_idx;

  always_comb begin
    new_hits  = valid & ~hit_map_q & {WIDTH{enable}};
    // Selector sees registered pending only, so a fresh hit waits one cycle.
    sel       = lowest_set(MAX_WIDTH'(pending_q));
    fifo_push = sel.found && !fifo_full;
    push_idx  = cover_idx_t'(COVER_INDEX) + cover_idx_t'(sel.index);

    pending_d = pending_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (fifo_push && sel.index == 8'(i)) pending_d[i] = 1'b0;
    end
    pending_d   = pending_d | new_hits;
    hit_map_d   = hit_map_q | new_hits;
    hit_count_d = hit_count_q + CntW'(popcount(MAX_WIDTH'(new_hits)));

    if (clear) begin
      pending_d   = '0;
      hit_map_d   = '0;
      hit_count_d = '0;
    end
    all_hit_d = (hit_count_d == CntW'(WIDTH));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_map_q   <= '0;
      pending_q   <= '0;
      hit_count_q <= '0;
      all_hit_q   <= 1'b0;
    end else begin
      hit_map_q   <= hit_map_d;
      pending_q   <= pending_d;
      hit_count_q <= hit_count_d;
      all_hit_q   <= all_hit_d;
    end
  end

  cover_idx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (clear),
    .push      (fifo_push),
    .push_data (push_idx),
    .full      (fifo_full),
    .pop       (report_ready),
    .empty     (fifo_empty),
    .head      (report_index)
  );

  assign report_valid = !fifo_empty;
  assign hit_map      = hit_map_q;
  assign hit_count    = hit_count_q;
  assign all_hit      = all_hit_q;

endmodule

// File: tb/tb_cover_toggle_collector.sv
// Randomised bench for cover_toggle_collector against a queue-based reference model.
module tb_cover_toggle_collector;

  localparam int unsigned W    = 40;
  localparam int unsigned BASE = 100;
  localparam int unsigned DEP  = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic [W-1:0]  valid;
  logic          clear;
  logic          report_valid;
  logic          report_ready;
  logic [63:0]   report_index;
  logic [W-1:0]  hit_map;
  logic [5:0]    hit_count;
  logic          all_hit;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: coverage set, outstanding-report set, report queue.
  logic [W-1:0]     m_hit;
  logic [W-1:0]     m_pend;
  int unsigned      m_fifo[$];
  logic [63:0]      got[$];

  cover_toggle_collector #(
    .WIDTH       (W),
    .COVER_INDEX (BASE),
    .COVER_TOTAL (8940),
    .FIFO_DEPTH  (DEP)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .valid        (valid),
    .clear        (clear),
    .report_valid (report_valid),
    .report_ready (report_ready),
    .report_index (report_index),
    .hit_map      (hit_map),
    .hit_count    (hit_count),
    .all_hit      (all_hit)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
    n_checks++;
    if (got_v !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got_v, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_hit  = '0;
    m_pend = '0;
    m_fifo.delete();
  endtask

  task automatic model_update();
    logic [W-1:0] nw;
    bit           can_push;
    int           b;
    if (!reset) begin
      model_reset();
      return;
    end
    if (clear) begin
      model_reset();
      return;
    end
    nw       = valid & ~m_hit & {W{enable}};
    can_push = (m_fifo.size() < DEP);
    b        = -1;
    for (int i = 0; i < W; i++) begin
      if (m_pend[i]) begin
        b = i;
        break;
      end
    end
    if (report_ready && m_fifo.size() > 0) void'(m_fifo.pop_front());
    if (can_push && b >= 0) begin
      m_fifo.push_back(BASE + b);
      m_pend[b] = 1'b0;
    end
    m_hit  = m_hit | nw;
    m_pend = m_pend | nw;
  endtask

  task automatic compare_all();
    int unsigned cnt;
    cnt = $countones(m_hit);
    check("report_valid", 64'(report_valid), 64'(m_fifo.size() > 0));
    check("report_index", report_index, (m_fifo.size() > 0) ? 64'(m_fifo[0]) : 64'd0);
    check("hit_map", 64'(hit_map), 64'(m_hit));
    check("hit_count", 64'(hit_count), 64'(cnt));
    check("all_hit", 64'(all_hit), 64'(cnt == W));
  endtask

  // One clock: record handshake, advance model, compare #1 after the edge.
  task automatic step();
    bit          fire;
    logic [63:0] idx;
    fire = report_valid && report_ready;
    idx  = report_index;
    @(posedge clock);
    if (fire) got.push_back(idx);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset        = 1'b0;
    enable       = 1'b1;
    valid        = '0;
    clear        = 1'b0;
    report_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("rst_valid", 64'(report_valid), 64'd0);
    check("rst_index", report_index, 64'd0);
    check("rst_map", 64'(hit_map), 64'd0);
    check("rst_count", 64'(hit_count), 64'd0);
    check("rst_all", 64'(all_hit), 64'd0);
    reset = 1'b1;

    // Single hit latency: map in cycle 1, report in cycle 2 for one cycle.
    valid = 40'h1;
    step();
    valid = '0;
    check("lat_map", 64'(hit_map), 64'd1);
    check("lat_rv_c1", 64'(report_valid), 64'd0);
    step();
    check("lat_rv_c2", 64'(report_valid), 64'd1);
    check("lat_idx_c2", report_index, 64'd100);
    step();
    check("lat_rv_c3", 64'(report_valid), 64'd0);
    check("lat_count", 64'(hit_count), 64'd1);

    // Three simultaneous hits report in ascending order.
    valid = (40'h1 << 3) | (40'h1 << 7) | (40'h1 << 39);
    step();
    valid = '0;
    step();
    check("multi_0", report_index, 64'd103);
    step();
    check("multi_1", report_index, 64'd107);
    step();
    check("multi_2", report_index, 64'd139);
    step();
    check("multi_done", 64'(report_valid), 64'd0);
    check("multi_count", 64'(hit_count), 64'd4);
    valid = (40'h1 << 3) | (40'h1 << 7) | (40'h1 << 39);
    step();
    valid = '0;
    steps(4);
    check("retoggle_rv", 64'(report_valid), 64'd0);

    // Full coverage under backpressure, then drain.
    clear = 1'b1;
    step();
    clear        = 1'b0;
    report_ready = 1'b0;
    valid        = '1;
    step();
    valid = '0;
    check("all_hit_c1", 64'(all_hit), 64'd1);
    steps(6);
    check("bp_head", report_index, 64'd100);
    got.delete();
    report_ready = 1'b1;
    steps(50);
    check("drain_len", 64'(got.size()), 64'd40);
    for (int i = 0; i < got.size() && i < W; i++) check("drain_order", got[i], 64'(BASE + i));

    // Clear with two entries queued and a new hit in the same cycle.
    clear = 1'b1;
    step();
    clear        = 1'b0;
    report_ready = 1'b0;
    valid        = 40'h6;
    step();
    valid = '0;
    steps(3);
    check("clr_queued", 64'(report_valid), 64'd1);
    clear = 1'b1;
    valid = 40'h1 << 5;
    step();
    clear = 1'b0;
    valid = '0;
    check("clr_rv", 64'(report_valid), 64'd0);
    check("clr_map", 64'(hit_map), 64'd0);
    check("clr_count", 64'(hit_count), 64'd0);
    steps(2);
    check("clr_bit5", 64'(hit_map[5]), 64'd0);

    // Enable gating.
    report_ready = 1'b1;
    enable       = 1'b0;
    valid        = '1;
    steps(2);
    check("en_off_map", 64'(hit_map), 64'd0);
    check("en_off_rv", 64'(report_valid), 64'd0);
    enable = 1'b1;
    step();
    valid = '0;
    check("en_on_map", 64'(hit_map), 64'hff_ffff_ffff);

    // Asynchronous reset mid-drain, between edges.
    steps(3);
    #3;
    reset = 1'b0;
    #1;
    check("arst_rv", 64'(report_valid), 64'd0);
    check("arst_idx", report_index, 64'd0);
    check("arst_map", 64'(hit_map), 64'd0);
    check("arst_count", 64'(hit_count), 64'd0);
    check("arst_all", 64'(all_hit), 64'd0);
    model_reset();
    #1;
    reset = 1'b1;
    valid = 40'h1;
    step();
    valid = '0;
    step();
    check("arst_fresh_rv", 64'(report_valid), 64'd1);
    check("arst_fresh_idx", report_index, 64'd100);

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      valid        = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) valid = valid & 40'h0f_0000_00ff;
      enable       = ($urandom_range(0, 9) != 0);
      report_ready = ($urandom_range(0, 2) != 0);
      clear        = ($urandom_range(0, 99) < 2);
      step();
    end
    clear = 1'b0;
    valid = '0;
    report_ready = 1'b1;
    steps(50);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
